// File: rtl/branch_redirect_ctrl_pkg.sv
// Shared branch-redirect types and constants.
// Also imported by the fetch and hazard units.
package branch_redirect_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REDIRECT = 2'd1,
    FLUSH    = 2'd2
  } brc_state_e;

  localparam int BRC_WIDTH   = 32;
  localparam int FLUSH_CNT_W = 3;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != '1))
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch resolution: redirect handshake,
// wrong-path drain, predictor update and statistics.
module branch_redirect_ctrl
  import branch_redirect_ctrl_pkg::*;
#(
  parameter int WIDTH        = BRC_WIDTH,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic             i_is_branch,
  input  logic             i_taken,
  input  logic             i_pred_taken,
  input  logic             i_PPC_Eq,
  input  logic [WIDTH-1:0] i_New_PC,
  input  logic [WIDTH-1:0] i_EX_PC,
  input  logic             i_fetch_ready,
  output logic             o_redirect_valid,
  output logic [WIDTH-1:0] o_redirect_pc,
  output logic             o_flush,
  output logic             o_busy,
  output logic             o_bp_upd_valid,
  output logic [WIDTH-1:0] o_bp_upd_pc,
  output logic [WIDTH-1:0] o_bp_upd_target,
  output logic             o_bp_upd_taken,
  output logic [CNT_W-1:0] o_branch_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam logic [FLUSH_CNT_W-1:0] DRAIN_INIT =
    FLUSH_CNT_W'(FLUSH_CYCLES);

  brc_state_e             state_q;
  logic [FLUSH_CNT_W-1:0] drain_q;
  logic                   rv_q;
  logic [WIDTH-1:0]       rpc_q;
  logic                   flush_q;
  logic                   busy_q;
  logic                   upd_v_q;
  logic [WIDTH-1:0]       upd_pc_q;
  logic [WIDTH-1:0]       upd_tgt_q;
  logic                   upd_tk_q;

  logic resolve;
  logic mispred;

  assign resolve = i_valid & i_is_branch
                 & (state_q == IDLE);
  assign mispred = resolve
                 & ((i_taken != i_pred_taken)
                 | (i_taken & i_pred_taken & ~i_PPC_Eq));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      drain_q   <= '0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
      flush_q   <= 1'b0;
      busy_q    <= 1'b0;
      upd_v_q   <= 1'b0;
      upd_pc_q  <= '0;
      upd_tgt_q <= '0;
      upd_tk_q  <= 1'b0;
    end else begin
      upd_v_q <= resolve;
      if (resolve) begin
        upd_pc_q  <= i_EX_PC;
        upd_tgt_q <= i_New_PC;
        upd_tk_q  <= i_taken;
      end
      unique case (state_q)
        IDLE: begin
          if (mispred) begin
            state_q <= REDIRECT;
            rv_q    <= 1'b1;
            rpc_q   <= i_New_PC;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        REDIRECT: begin
          if (i_fetch_ready) begin
            rv_q <= 1'b0;
            if (FLUSH_CYCLES == 0) begin
              state_q <= IDLE;
              flush_q <= 1'b0;
              busy_q  <= 1'b0;
            end else begin
              state_q <= FLUSH;
              drain_q <= DRAIN_INIT;
            end
          end
        end
        FLUSH: begin
          drain_q <= drain_q - 1'b1;
          if (drain_q == FLUSH_CNT_W'(1)) begin
            state_q <= IDLE;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_br_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (resolve),
    .count (o_branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mp_cnt (
    .clk   (i_clk),
    .rst   (i_rst),
    .inc   (mispred),
    .count (o_mispred_cnt)
  );

  assign o_redirect_valid = rv_q;
  assign o_redirect_pc    = rpc_q;
  assign o_flush          = flush_q;
  assign o_busy           = busy_q;
  assign o_bp_upd_valid   = upd_v_q;
  assign o_bp_upd_pc      = upd_pc_q;
  assign o_bp_upd_target  = upd_tgt_q;
  assign o_bp_upd_taken   = upd_tk_q;

endmodule

// File: doc/branch_redirect_ctrl.md
# branch_redirect_ctrl

Execute-stage controller that sequences the PC evaluation result of each resolved branch into pipeline actions. It detects mispredictions from the branch unit's outcome and the predicted-PC comparison, and issues a redirect handshake to fetch. It flushes the IF/ID wrong-path instructions for a configurable drain period and emits one predictor-update pulse per resolved branch. It also maintains saturating branch and mispredict counters.

## Interface
Parameters:
- `WIDTH`, 32, address width.
- `FLUSH_CYCLES`, 2, drain cycles after redirect acceptance; legal range 0..7.
- `CNT_W`, 16, statistics counter width.

Ports:
- `i_clk`  in  1  clock; all logic on rising edge.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_valid`  in  1  EX stage holds a valid instruction.
- `i_is_branch`  in  1  EX instruction is a branch or jump.
- `i_taken`  in  1  branch unit resolved taken.
- `i_pred_taken`  in  1  fetch predicted taken.
- `i_PPC_Eq`  in  1  predicted PC equals ALU target.
- `i_New_PC`  in  WIDTH  resolved next PC from PC evaluation.
- `i_EX_PC`  in  WIDTH  address of the EX instruction.
- `i_fetch_ready`  in  1  fetch accepts a redirect this cycle.
- `o_redirect_valid`  out  1  redirect request to fetch.
- `o_redirect_pc`  out  WIDTH  redirect target.
- `o_flush`  out  1  squash IF/ID contents; suppress EX commit.
- `o_busy`  out  1  controller not IDLE.
- `o_bp_upd_valid`  out  1  one-cycle predictor update pulse.
- `o_bp_upd_pc`, `o_bp_upd_target`  out  WIDTH  branch address and resolved target.
- `o_bp_upd_taken`  out  1  resolved direction.
- `o_branch_cnt`, `o_mispred_cnt`  out  CNT_W  saturating statistics.

## Operation
- Resolve condition: `resolve = i_valid & i_is_branch & (state == IDLE)`.
- Mispredict condition: `mispred = resolve & ((i_taken != i_pred_taken) | (i_taken & i_pred_taken & ~i_PPC_Eq))`.
- Correct predictions cause no redirect and no flush.
- States:
  - IDLE → REDIRECT on `mispred`. The controller latches `i_New_PC` into `o_redirect_pc`.
  - REDIRECT holds `o_redirect_valid=1` until `i_fetch_ready`. On acceptance, it goes to FLUSH with the drain counter loaded to FLUSH_CYCLES. If FLUSH_CYCLES=0, it goes directly to IDLE.
  - FLUSH decrements the counter each cycle and returns to IDLE when the counter reads 1 at the clock edge.
- `o_flush=1` in REDIRECT and FLUSH. `o_busy=1` in any state other than IDLE.
- Outside IDLE, all EX inputs are wrong-path and are ignored: no update, no count, no new redirect.
- Every `resolve` produces one `o_bp_upd_valid` pulse, whether or not the branch mispredicted. The pulse carries `i_EX_PC`, `i_New_PC` and `i_taken`.
- `o_branch_cnt` increments on every `resolve`. `o_mispred_cnt` increments on every `mispred`. Both saturate at all-ones and never wrap.
- `o_redirect_pc` holds its value until the next mispredict.

## Timing
- All outputs are registered.
- Reset values:
  - `o_redirect_valid`, `o_flush`, `o_busy`, `o_bp_upd_valid`, `o_bp_upd_taken` = 0.
  - `o_redirect_pc`, `o_bp_upd_pc`, `o_bp_upd_target` = 0.
  - Both counters = 0. State = IDLE.
- Mispredict sampled at edge T:
  - From T+1: `o_redirect_valid`, `o_flush`, `o_busy` and `o_bp_upd_valid` (one cycle only) are high.
  - Counters show their new values at T+1.
- Handshake: the transfer occurs on the edge where `o_redirect_valid & i_fetch_ready`.
  - If `i_fetch_ready` is already high at T+1, REDIRECT lasts exactly one cycle.
  - `o_redirect_valid` drops on the cycle after acceptance.
  - `o_redirect_pc` is stable while valid is high.
- Flush duration: `o_flush` stays high for the REDIRECT cycles plus FLUSH_CYCLES. It falls together with `o_busy`.
- A branch presented on the first IDLE cycle after FLUSH is resolved normally, giving back-to-back mispredict support.
- Reset asserted in any state returns to IDLE on the next edge. Any pending redirect is abandoned, and no pulse or count is generated in that cycle.
- Counter saturation: at all-ones, further events leave the counter unchanged.

## Structure
- Shared package holds:
  - the state enum (IDLE, REDIRECT, FLUSH);
  - the `WIDTH` default constant;
  - a `FLUSH_CNT_W = 3` constant.
- The package is reused by the fetch and hazard units.
- One sub-module, `sat_counter` (parameter CNT_W; inputs clk, rst, inc; output count), is instantiated twice for the statistics counters.
- The FSM, redirect register and update register live in the top module.

## Test plan
- Correct not-taken branch (pred=0, taken=0) at `i_EX_PC=0x100`, `i_New_PC=0x104` → one `o_bp_upd_valid` pulse with pc 0x100, target 0x104, taken 0. No redirect, no flush. `o_branch_cnt=1`, `o_mispred_cnt=0`.
- Direction mispredict (pred=0, taken=1, `i_New_PC=0x200`), `i_fetch_ready=1` → at T+1 redirect to 0x200. Redirect valid for 1 cycle. `o_flush` high for 3 cycles with FLUSH_CYCLES=2. `o_mispred_cnt=1`.
- Target mispredict (pred=1, taken=1, `i_PPC_Eq=0`), `i_fetch_ready` low for 4 cycles → `o_redirect_valid` is held 5 cycles with a constant pc. Branches presented meanwhile produce no pulses and no counts.
- Back-to-back: a second mispredict on the first IDLE cycle → a second redirect is issued and both counters reach 2.
- Reset asserted while in REDIRECT → next cycle all outputs are 0, state is IDLE, and counters are cleared.
- Saturation with CNT_W=4: 20 resolves → `o_branch_cnt` stays at 15.
